// File: rtl/mult_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mult_rr_scheduler
//   Lets four requesters share one signed fixed-point multiplier.
//   Requests are granted round-robin. Each granted request is multiplied in
//   the shared multiplicador instance. The product is rescaled to Q(FRAC)
//   with saturation and returned on a valid/ready result port.
//
//   multiplicador : full-width signed multiplier (a_i * b_i -> p_o, 2N bits).
//
// Ports (mult_rr_scheduler):
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [4]     request pending, one bit per requester
//   req_a      in   [4*N]   operand A, requester i at [i*N +: N], signed
//   req_b      in   [4*N]   operand B, same packing
//   req_ack    out  [4]     one-hot grant, combinational, IDLE only
//   res_valid  out          result available
//   res_ready  in           consumer accepts result
//   res_id     out  [2]     requester owning the result
//   res_data   out  [N]     scaled, saturated product (signed)
//   res_sat    out          saturation occurred for this result
//   busy       out          state is not IDLE
// ---------------------------------------------------------------------------
module multiplicador #(
  parameter int N = 16
) (
  input  logic signed [N-1:0]   a_i,
  input  logic signed [N-1:0]   b_i,
  output logic signed [2*N-1:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

module mult_rr_scheduler #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req_valid,
  input  logic [4*N-1:0] req_a,
  input  logic [4*N-1:0] req_b,
  output logic [3:0]     req_ack,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [1:0]     res_id,
  output logic [N-1:0]   res_data,
  output logic           res_sat,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Largest / smallest N-bit signed values, sign-extended to 2N bits.
  localparam logic signed [2*N-1:0] MAX_S = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MIN_S = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  state_t                state_q, state_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic signed [N-1:0]   op_a_q, op_a_d;
  logic signed [N-1:0]   op_b_q, op_b_d;
  logic [1:0]            id_q, id_d;
  logic                  res_valid_q, res_valid_d;
  logic [1:0]            res_id_q, res_id_d;
  logic [N-1:0]          res_data_q, res_data_d;
  logic                  res_sat_q, res_sat_d;

  logic                  found;
  logic [1:0]            grant_idx;
  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] shifted;
  logic [N-1:0]          sat_data;
  logic                  sat_flag;

  // Round-robin search starting one past the last grant; k=4 wraps back to
  // last_grant itself so a lone requester can be granted repeatedly.
  always_comb begin
    logic [1:0] cand;
    found     = 1'b0;
    grant_idx = last_grant_q;
    cand      = last_grant_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Ack is suppressed in the reset cycle so no handshake completes on it.
  assign req_ack = (state_q == IDLE && !reset && found) ? (4'b0001 << grant_idx) : 4'b0000;

  multiplicador #(.N(N)) u_mult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (prod)
  );

  // Arithmetic shift floors toward minus infinity; then clamp to N bits.
  always_comb begin
    shifted  = prod >>> FRAC;
    sat_data = shifted[N-1:0];
    sat_flag = 1'b0;
    if (shifted > MAX_S) begin
      sat_data = {1'b0, {(N-1){1'b1}}};
      sat_flag = 1'b1;
    end else if (shifted < MIN_S) begin
      sat_data = {1'b1, {(N-1){1'b0}}};
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    id_d         = id_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_data_d   = res_data_q;
    res_sat_d    = res_sat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d       = req_a[int'(grant_idx)*N +: N];
          op_b_d       = req_b[int'(grant_idx)*N +: N];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        res_data_d  = sat_data;
        res_sat_d   = sat_flag;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      op_a_q       <= '0;
      op_b_q       <= '0;
      id_q         <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_data_q   <= '0;
      res_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      id_q         <= id_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_data_q   <= res_data_d;
      res_sat_q    <= res_sat_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_sat   = res_sat_q;
  assign busy      = (state_q != IDLE);

endmodule
